// File: rtl/mips_pkg.sv
// mips_pkg: items shared by the memory-stage control logic.
//   state_t     : memory-stage FSM state encoding (IDLE, WAIT, FLUSH)
//   M_BRANCH    : index of the branch bit in the EX/MEM m_ctl field
//   M_MEMREAD   : index of the memread bit in m_ctl
//   M_MEMWRITE  : index of the memwrite bit in m_ctl
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

endpackage : mips_pkg

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock, rising-edge
//   inc   : count this cycle
//   clear : synchronous clear, takes priority over inc
//   q     : current count (W bits)
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule : sat_counter

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage sequencer for the 5-stage MIPS pipeline.
// Drives the data-memory handshake, stalls the pipeline while an access is
// outstanding, turns a taken branch into a one-cycle pc_src/flush pulse, and
// counts stall cycles.
//
// Optional feature macro: MEM_WAIT_TIMEOUT_EN
//   defined   -> a WAIT that sees no dmem_ready for TIMEOUT cycles (counted
//                from the request) is aborted and err is set (sticky).
//   undefined -> WAIT lasts until dmem_ready; err is tied to 0.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-low
//   mem_valid    in   EX/MEM holds a real instruction
//   m_ctl[2:0]   in   {branch, memread, memwrite}
//   zero         in   ALU zero flag
//   dmem_ready   in   memory completes access this cycle
//   dmem_req     out  data-memory request
//   dmem_we      out  write enable qualifying dmem_req
//   stall        out  hold PC, IF/ID, ID/EX, EX/MEM
//   memwb_bubble out  load zeroed WB control into MEM/WB
//   pc_src       out  select branch target as next PC
//   flush        out  zero IF/ID, ID/EX, EX/MEM at next edge
//   stall_count  out  saturating count of stall cycles
//   err          out  sticky access-timeout flag
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no access outstanding; accept access or resolve branch
// ST_WAIT  | access issued, waiting for dmem_ready
// ST_FLUSH | one dead cycle after a taken branch; all pulses low
module mem_stage_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_valid,
  input  logic [2:0]       m_ctl,
  input  logic             zero,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             stall,
  output logic             memwb_bubble,
  output logic             pc_src,
  output logic             flush,
  output logic [CNT_W-1:0] stall_count,
  output logic             err
);

  state_t state, state_nxt;
  logic   access, take;

  assign access = mem_valid & (m_ctl[M_MEMREAD] | m_ctl[M_MEMWRITE]);
  // A branch decoded together with a memory op is illegal; the access wins.
  assign take   = mem_valid & m_ctl[M_BRANCH] & zero
                & ~m_ctl[M_MEMREAD] & ~m_ctl[M_MEMWRITE];

`ifdef MEM_WAIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          timeout_hit;
  logic          err_q;
`endif

  always_comb begin
    state_nxt    = state;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    stall        = 1'b0;
    memwb_bubble = 1'b0;
    pc_src       = 1'b0;
    flush        = 1'b0;
`ifdef MEM_WAIT_TIMEOUT_EN
    timeout_hit  = 1'b0;
`endif
    // While reset is low every combinational output stays 0, dropping any
    // outstanding request.
    if (reset) begin
      case (state)
        ST_IDLE: begin
          if (access) begin
            dmem_req = 1'b1;
            dmem_we  = m_ctl[M_MEMWRITE];
            if (!dmem_ready) begin
              stall        = 1'b1;
              memwb_bubble = 1'b1;
              state_nxt    = ST_WAIT;
            end
          end else if (take) begin
            pc_src    = 1'b1;
            flush     = 1'b1;
            state_nxt = ST_FLUSH;
          end
        end
        ST_WAIT: begin
          dmem_req = 1'b1;
          dmem_we  = m_ctl[M_MEMWRITE];
          if (dmem_ready) begin
            state_nxt = ST_IDLE;
          end
`ifdef MEM_WAIT_TIMEOUT_EN
          else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            dmem_req     = 1'b0;
            dmem_we      = 1'b0;
            memwb_bubble = 1'b1;
            timeout_hit  = 1'b1;
            state_nxt    = ST_IDLE;
          end
`endif
          else begin
            stall        = 1'b1;
            memwb_bubble = 1'b1;
          end
        end
        ST_FLUSH: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef MEM_WAIT_TIMEOUT_EN
  // wait_cnt = cycles already waited since the request. It restarts at 1 on
  // WAIT entry because the IDLE request cycle was the first waited cycle, so
  // the abort lands on the TIMEOUT-th cycle after the request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if ((state != ST_WAIT) && (state_nxt == ST_WAIT)) begin
      wait_cnt <= TW'(1);
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .inc   (stall),
    .clear (~reset),
    .q     (stall_count)
  );

endmodule : mem_stage_ctrl
